// File: rtl/hyperbus_rwds_rx_if.sv
// Word stream from the RWDS receiver to the uDMA RX channel.
// The master drives data and valid; the slave returns ready.
interface hyperbus_rwds_rx_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/hyperbus_rwds_rx.sv
// HyperBus read-data receiver: RWDS edges pair DQ bytes into 16-bit words, counted against the burst length.
// A word is visible one cycle after its falling-edge detect; a word that meets a full FIFO with no pop is dropped (sticky overflow).
module hyperbus_rwds_rx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [15:0]          len_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [7:0]           dq_i,
    input  logic                 rwds_i,
    hyperbus_rwds_rx_if.master   rx,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 overflow_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 rwds_q;
    logic [15:0]          words_left;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 half_valid;
    logic [7:0]           hi_byte;

    logic [15:0]          mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, pop, push_ok;

    logic rise, fall, strobe_edge, in_recv;
    logic start_burst, start_empty, push_req, last_word, tmo_hit;

    assign rise        = rwds_i & ~rwds_q;
    assign fall        = ~rwds_i & rwds_q;
    assign strobe_edge = rise | fall;
    assign in_recv     = (state_q == RECV);

    assign start_burst = ~in_recv & start_i & (len_i != 16'd0);
    assign start_empty = ~in_recv & start_i & (len_i == 16'd0);
    assign push_req    = in_recv & fall & half_valid;
    assign last_word   = push_req & (words_left == 16'd1);
    // An edge in the timeout cycle keeps the burst alive.
    assign tmo_hit     = in_recv & ~strobe_edge & (timeout_i != '0)
                       & (tmo_cnt == timeout_i - TIMEOUT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_burst) state_d = RECV;
            RECV:    if (last_word || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RECV);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rwds_q     <= 1'b0;
            words_left <= 16'd0;
            tmo_cnt    <= '0;
            half_valid <= 1'b0;
            hi_byte    <= 8'd0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            rwds_q    <= rwds_i;
            done_o    <= start_empty | last_word;
            timeout_o <= tmo_hit;
            if (start_burst) begin
                words_left <= len_i;
                tmo_cnt    <= '0;
                half_valid <= 1'b0;
                overflow_o <= 1'b0;
            end else if (in_recv) begin
                tmo_cnt <= strobe_edge ? '0 : tmo_cnt + TIMEOUT_W'(1);
                if (rise) begin
                    hi_byte    <= dq_i;
                    half_valid <= 1'b1;
                end
                if (push_req) begin
                    half_valid <= 1'b0;
                    words_left <= words_left - 16'd1;
                    if (!push_ok) overflow_o <= 1'b1;
                end
                if (tmo_hit) half_valid <= 1'b0;
            end
        end
    end

    // Extra pointer MSB separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rx.rx_valid & rx.rx_ready;
    assign push_ok    = push_req & (~fifo_full | pop);

    assign rx.rx_valid = ~fifo_empty;
    assign rx.rx_data  = fifo_empty ? 16'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {hi_byte, dq_i};
    end

endmodule

// File: tb/tb_hyperbus_rwds_rx.sv
// Randomised and directed bench for hyperbus_rwds_rx against a queue-based burst model.
module tb_hyperbus_rwds_rx;
    localparam int DEPTH = 4;
    localparam int TW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   len = 16'd0;
    logic [TW-1:0] tmo = '0;
    logic [7:0]    dq = 8'd0;
    logic          rwds = 1'b0;
    logic          ready = 1'b1;
    logic          busy, done, tmo_o, ovf;

    hyperbus_rwds_rx_if rx_if ();
    assign rx_if.rx_ready = ready;

    hyperbus_rwds_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .timeout_i(tmo),
        .dq_i(dq), .rwds_i(rwds), .rx(rx_if), .busy_o(busy), .done_o(done),
        .timeout_o(tmo_o), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] got[$];
    logic [15:0] sent[$];

    // Reference model: burst-level view with the FIFO as a bounded queue.
    logic [15:0] m_q[$];
    bit          m_busy, m_half, m_done, m_tmo, m_ovf, m_prev;
    int          m_left, m_cnt;
    logic [7:0]  m_hi;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_half = 0; m_done = 0; m_tmo = 0; m_ovf = 0; m_prev = 0;
        m_left = 0; m_cnt = 0; m_hi = 8'd0;
    endtask

    task automatic model_step();
        bit rs, fl, pp, full;
        pp   = (m_q.size() > 0) && ready;
        full = (m_q.size() >= DEPTH);
        rs   = rwds && !m_prev;
        fl   = !rwds && m_prev;
        m_done = 0;
        m_tmo  = 0;
        if (pp) void'(m_q.pop_front());
        if (!m_busy) begin
            if (start) begin
                if (len == 0) m_done = 1;
                else begin
                    m_busy = 1; m_left = len; m_cnt = 0; m_half = 0; m_ovf = 0;
                end
            end
        end else begin
            if (rs) begin
                m_hi = dq;
                m_half = 1;
            end
            if (fl && m_half) begin
                m_half = 0;
                m_left--;
                if (!full || pp) m_q.push_back({m_hi, dq});
                else m_ovf = 1;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (tmo != 0 && !rs && !fl && m_cnt == int'(tmo) - 1) begin
                m_busy = 0; m_tmo = 1; m_half = 0;
            end
            m_cnt = (rs || fl) ? 0 : (m_cnt + 1) % 256;
        end
        m_prev = rwds;
    endtask

    task automatic check_all();
        chk("rx_valid", 32'(rx_if.rx_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("rx_data", 32'(rx_if.rx_data), 32'(m_q[0]));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("timeout", 32'(tmo_o), 32'(m_tmo));
        chk("overflow", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        if (rx_if.rx_valid && ready) got.push_back(rx_if.rx_data);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic strobe(bit lvl, logic [7:0] d);
        rwds = lvl;
        dq = d;
        tick();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            dq = 8'($urandom);
            tick();
        end
    endtask

    task automatic word(logic [7:0] h, logic [7:0] l);
        sent.push_back({h, l});
        strobe(1'b1, h);
        strobe(1'b0, l);
    endtask

    task automatic go(int l);
        start = 1'b1;
        len = 16'(l);
        tick();
        start = 1'b0;
        len = 16'($urandom);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo_o), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd0);
        chk({tag, "_data"}, 32'(rx_if.rx_data), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tp, rp;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic two-word burst.
        got.delete();
        go(2);
        strobe(1'b1, 8'hA5); strobe(1'b0, 8'h3C); strobe(1'b1, 8'h0F); strobe(1'b0, 8'hF0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        idle(3);
        chk("t1_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t1_w0", 32'(got[0]), 32'h0000A53C);
            chk("t1_w1", 32'(got[1]), 32'h00000FF0);
        end

        // Zero-length burst.
        go(0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        idle(2);
        chk("t2_valid", 32'(rx_if.rx_valid), 32'd0);

        // Overflow with a stalled consumer, cleared by the next start.
        ready = 1'b0; got.delete(); sent.delete();
        go(6);
        repeat (6) word(8'($urandom), 8'($urandom));
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_ovf", 32'(ovf), 32'd1);
        go(1);
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        tmo = 8'd3;
        idle(5);
        ready = 1'b1;
        idle(6);
        chk("t3_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t3_word", 32'(got[i]), 32'(sent[i]));

        // Inactivity timeout five cycles after the last edge.
        ready = 1'b0; got.delete(); tmo = 8'd5;
        go(3);
        word(8'h11, 8'h22);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("t4_early_tmo", 32'(tmo_o), 32'd0);
        end
        idle(1);
        chk("t4_tmo", 32'(tmo_o), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valid", 32'(rx_if.rx_valid), 32'd1);
        ready = 1'b1;
        idle(2);
        chk("t4_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("t4_w0", 32'(got[0]), 32'h00001122);
        tmo = 8'd0;

        // RWDS already high when the burst starts.
        got.delete();
        rwds = 1'b1;
        idle(2);
        go(1);
        strobe(1'b0, 8'h77);
        idle(1);
        chk("t5_nopush", 32'(rx_if.rx_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        word(8'hBE, 8'hEF);
        idle(2);
        chk("t5_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("t5_w0", 32'(got[0]), 32'h0000BEEF);

        // Push into a full FIFO while it pops.
        ready = 1'b0; got.delete(); sent.delete();
        go(5);
        repeat (4) word(8'($urandom), 8'($urandom));
        sent.push_back(16'hC3D4);
        strobe(1'b1, 8'hC3);
        ready = 1'b1;
        strobe(1'b0, 8'hD4);
        ready = 1'b0;
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_done", 32'(done), 32'd1);
        ready = 1'b1;
        idle(6);
        chk("t6_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t6_word", 32'(got[i]), 32'(sent[i]));

        // Asynchronous reset mid-burst with data buffered.
        ready = 1'b0;
        go(3);
        word(8'h5A, 8'hA5);
        strobe(1'b1, 8'h99);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Randomised traffic.
        got.delete();
        tp = 50; rp = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                tmo = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
                tp  = $urandom_range(5, 90);
                rp  = $urandom_range(0, 100);
            end
            start = ($urandom_range(0, 24) == 0);
            len   = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 99) < tp) rwds = ~rwds;
            dq    = 8'($urandom);
            ready = ($urandom_range(0, 99) < rp);
            tick();
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
